// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and constants for the stream demultiplexer.
//   state_t   frame FSM encoding (ST_IDLE, ST_FRAME)
//   DST_OUT0  destination code for output 0
//   DST_OUT1  destination code for output 1
package stream_demux_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  localparam logic DST_OUT0 = 1'b0;
  localparam logic DST_OUT1 = 1'b1;

endpackage

// File: rtl/stream_reg_slice.sv
// stream_reg_slice: one-entry valid/ready holding register.
//
// Handshake: a beat transfers on any rising edge where vld and rdy are both
// high; a producer holds vld and its payload stable until that edge, and rdy
// may depend combinationally on the downstream rdy.
//
// Ports:
//   clk_sig      in   clock
//   rst_sig      in   synchronous active-high reset (empties the slot, clears data)
//   in_vld_sig   in   upstream valid
//   in_rdy_sig   out  upstream ready = slot empty or slot draining this cycle
//   in_dat_sig   in   upstream payload
//   out_vld_sig  out  slot holds a beat
//   out_rdy_sig  in   downstream ready for the held beat
//   out_dat_sig  out  held payload
module stream_reg_slice #(
  parameter int W = 18
) (
  input  logic         clk_sig,
  input  logic         rst_sig,
  input  logic         in_vld_sig,
  output logic         in_rdy_sig,
  input  logic [W-1:0] in_dat_sig,
  output logic         out_vld_sig,
  input  logic         out_rdy_sig,
  output logic [W-1:0] out_dat_sig
);

  logic         buf_vld;
  logic [W-1:0] buf_dat;
  logic         push;
  logic         pop;

  assign pop        = buf_vld & out_rdy_sig;
  // Accepting while draining gives full throughput through a single entry.
  assign in_rdy_sig = ~buf_vld | pop;
  assign push       = in_vld_sig & in_rdy_sig;

  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      buf_vld <= 1'b0;
      buf_dat <= '0;
    end else if (push) begin
      buf_vld <= 1'b1;
      buf_dat <= in_dat_sig;
    end else if (pop) begin
      buf_vld <= 1'b0;
    end
  end

  assign out_vld_sig = buf_vld;
  assign out_dat_sig = buf_dat;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: one-input, two-output valid/ready demultiplexer with a single
// registered holding stage and per-output completed-frame counters.
//
// Optional feature macro: DEMUX_FRAME_LOCK_EN
//   defined   - frame FSM locks the destination chosen on the first beat of a
//               frame until the beat carrying in_last_sig
//   undefined - destination is sel_sig sampled at every accepted beat
//
// Ports:
//   clk_sig        in   clock, rising edge
//   rst_sig        in   synchronous active-high reset
//   sel_sig        in   destination select (0 -> out0, 1 -> out1)
//   in_vld_sig     in   input valid
//   in_rdy_sig     out  input ready (combinational from the selected outN_rdy_sig)
//   in_dat_sig     in   input data
//   in_last_sig    in   last beat of frame
//   outN_vld_sig   out  output valid, only on the buffered beat's destination
//   outN_rdy_sig   in   output ready
//   outN_dat_sig   out  output data, shared holding register
//   outN_last_sig  out  output last, shared holding register
//   frmN_cnt_sig   out  saturating count of frames completed on outN
//   dbg_state_sig  out  frame FSM state (constant ST_IDLE without frame lock)
import stream_demux_pkg::*;

module stream_demux #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_sig,
  input  logic                 rst_sig,
  input  logic                 sel_sig,
  input  logic                 in_vld_sig,
  output logic                 in_rdy_sig,
  input  logic [WIDTH-1:0]     in_dat_sig,
  input  logic                 in_last_sig,
  output logic                 out0_vld_sig,
  input  logic                 out0_rdy_sig,
  output logic [WIDTH-1:0]     out0_dat_sig,
  output logic                 out0_last_sig,
  output logic                 out1_vld_sig,
  input  logic                 out1_rdy_sig,
  output logic [WIDTH-1:0]     out1_dat_sig,
  output logic                 out1_last_sig,
  output logic [CNT_WIDTH-1:0] frm0_cnt_sig,
  output logic [CNT_WIDTH-1:0] frm1_cnt_sig,
  output state_t               dbg_state_sig
);

  localparam int PW = WIDTH + 2;

  logic             dst;
  logic             push;
  logic             pop;
  logic             out_rdy;
  logic             buf_vld;
  logic             buf_dst;
  logic             buf_last;
  logic [WIDTH-1:0] buf_dat;
  logic [PW-1:0]    slice_in;
  logic [PW-1:0]    slice_out;

  assign slice_in = {dst, in_last_sig, in_dat_sig};
  assign {buf_dst, buf_last, buf_dat} = slice_out;

  // Only the buffered beat's own destination may drain the slot.
  assign out_rdy = (buf_dst == DST_OUT1) ? out1_rdy_sig : out0_rdy_sig;
  assign pop     = buf_vld & out_rdy;
  assign push    = in_vld_sig & in_rdy_sig;

  stream_reg_slice #(
    .W (PW)
  ) u_slice (
    .clk_sig     (clk_sig),
    .rst_sig     (rst_sig),
    .in_vld_sig  (in_vld_sig),
    .in_rdy_sig  (in_rdy_sig),
    .in_dat_sig  (slice_in),
    .out_vld_sig (buf_vld),
    .out_rdy_sig (out_rdy),
    .out_dat_sig (slice_out)
  );

`ifdef DEMUX_FRAME_LOCK_EN
  state_t state;
  state_t state_nxt;
  logic   lock_dst;
  logic   lock_nxt;

  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      state    <= ST_IDLE;
      lock_dst <= DST_OUT0;
    end else begin
      state    <= state_nxt;
      lock_dst <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_dst;
    case (state)
      ST_IDLE: begin
        if (push) begin
          lock_nxt = sel_sig;
          // Single-beat frames never open a frame.
          if (!in_last_sig) state_nxt = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (push && in_last_sig) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // First beat of a frame steers by sel_sig directly, so a new frame to the
  // other output needs no bubble.
  assign dst           = (state == ST_FRAME) ? lock_dst : sel_sig;
  assign dbg_state_sig = state;
`else
  assign dst           = sel_sig;
  assign dbg_state_sig = ST_IDLE;
`endif

  assign out0_vld_sig  = buf_vld & (buf_dst == DST_OUT0);
  assign out1_vld_sig  = buf_vld & (buf_dst == DST_OUT1);
  assign out0_dat_sig  = buf_dat;
  assign out1_dat_sig  = buf_dat;
  assign out0_last_sig = buf_last;
  assign out1_last_sig = buf_last;

  // Frame counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      frm0_cnt_sig <= '0;
      frm1_cnt_sig <= '0;
    end else if (pop && buf_last) begin
      if (buf_dst == DST_OUT0) begin
        if (frm0_cnt_sig != {CNT_WIDTH{1'b1}}) frm0_cnt_sig <= frm0_cnt_sig + 1'b1;
      end else begin
        if (frm1_cnt_sig != {CNT_WIDTH{1'b1}}) frm1_cnt_sig <= frm1_cnt_sig + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed bench for stream_demux (WIDTH=16, CNT_WIDTH=2).
// Expected values are hand-computed; frame-lock expectations follow
// DEMUX_FRAME_LOCK_EN when it is defined for the build.
import stream_demux_pkg::*;

module tb_stream_demux;

  localparam int WIDTH     = 16;
  localparam int CNT_WIDTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 sel;
  logic                 in_vld;
  logic                 in_rdy;
  logic [WIDTH-1:0]     in_dat;
  logic                 in_last;
  logic                 out0_vld, out1_vld;
  logic                 out0_rdy, out1_rdy;
  logic [WIDTH-1:0]     out0_dat, out1_dat;
  logic                 out0_last, out1_last;
  logic [CNT_WIDTH-1:0] frm0_cnt, frm1_cnt;
  state_t               dbg_state;

  stream_demux #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk_sig       (clk),
    .rst_sig       (rst),
    .sel_sig       (sel),
    .in_vld_sig    (in_vld),
    .in_rdy_sig    (in_rdy),
    .in_dat_sig    (in_dat),
    .in_last_sig   (in_last),
    .out0_vld_sig  (out0_vld),
    .out0_rdy_sig  (out0_rdy),
    .out0_dat_sig  (out0_dat),
    .out0_last_sig (out0_last),
    .out1_vld_sig  (out1_vld),
    .out1_rdy_sig  (out1_rdy),
    .out1_dat_sig  (out1_dat),
    .out1_last_sig (out1_last),
    .frm0_cnt_sig  (frm0_cnt),
    .frm1_cnt_sig  (frm1_cnt),
    .dbg_state_sig (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_vld  = 1'b0;
    in_dat  = '0;
    in_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer one beat (expects immediate acceptance), then check it sits on
  // exp_dst the following cycle.
  task automatic send_beat(input string tag, input logic s, input logic [WIDTH-1:0] d,
                           input logic l, input logic exp_dst);
    sel     = s;
    in_vld  = 1'b1;
    in_dat  = d;
    in_last = l;
    check({tag, ".in_rdy"}, 32'(in_rdy), 32'd1);
    tick();
    idle_in();
    check({tag, ".vld0"}, 32'(out0_vld), 32'(exp_dst == 1'b0));
    check({tag, ".vld1"}, 32'(out1_vld), 32'(exp_dst == 1'b1));
    if (exp_dst) begin
      check({tag, ".dat1"},  32'(out1_dat),  32'(d));
      check({tag, ".last1"}, 32'(out1_last), 32'(l));
    end else begin
      check({tag, ".dat0"},  32'(out0_dat),  32'(d));
      check({tag, ".last0"}, 32'(out0_last), 32'(l));
    end
  endtask

  logic exp_d;

  initial begin
    sel      = 1'b0;
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    idle_in();

    // ---- reset state ----
    do_reset();
    check("rst.vld0",  32'(out0_vld),  32'd0);
    check("rst.vld1",  32'(out1_vld),  32'd0);
    check("rst.dat0",  32'(out0_dat),  32'd0);
    check("rst.last1", 32'(out1_last), 32'd0);
    check("rst.in_rdy", 32'(in_rdy),   32'd1);
    check("rst.cnt0",  32'(frm0_cnt),  32'd0);
    check("rst.cnt1",  32'(frm1_cnt),  32'd0);
    check("rst.state", 32'(dbg_state), 32'(ST_IDLE));

    // ---- single beat to out1 ----
    out1_rdy = 1'b1;
    send_beat("single", 1'b1, 16'h1234, 1'b1, 1'b1);
    check("single.state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    check("single.cnt1", 32'(frm1_cnt), 32'd1);
    check("single.cnt0", 32'(frm0_cnt), 32'd0);
    check("single.drained", 32'(out1_vld), 32'd0);

    // ---- 4-beat frame with sel toggling every cycle ----
    do_reset();
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef DEMUX_FRAME_LOCK_EN
      exp_d = 1'b0;
`else
      exp_d = 1'(i % 2);
`endif
      send_beat($sformatf("lock%0d", i), 1'(i % 2), 16'(16'hA0 + i), 1'(i == 3), exp_d);
`ifdef DEMUX_FRAME_LOCK_EN
      if (i < 3) check($sformatf("lock%0d.state", i), 32'(dbg_state), 32'(ST_FRAME));
`endif
    end
    tick();
`ifdef DEMUX_FRAME_LOCK_EN
    check("lock.cnt0",  32'(frm0_cnt),  32'd1);
    check("lock.cnt1",  32'(frm1_cnt),  32'd0);
    check("lock.state", 32'(dbg_state), 32'(ST_IDLE));
`else
    check("lock.cnt0",  32'(frm0_cnt),  32'd0);
    check("lock.cnt1",  32'(frm1_cnt),  32'd1);
`endif

    // ---- back-to-back frames out0 then out1, no bubble ----
    do_reset();
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    send_beat("b2b0", 1'b0, 16'h00B0, 1'b0, 1'b0);
    send_beat("b2b1", 1'b0, 16'h00B1, 1'b1, 1'b0);
    send_beat("b2b2", 1'b1, 16'h00C0, 1'b0, 1'b1);
    send_beat("b2b3", 1'b1, 16'h00C1, 1'b1, 1'b1);
    check("b2b.cnt0_mid", 32'(frm0_cnt), 32'd1);
    tick();
    check("b2b.cnt0", 32'(frm0_cnt), 32'd1);
    check("b2b.cnt1", 32'(frm1_cnt), 32'd1);

    // ---- output stall with full buffer ----
    do_reset();
    out0_rdy = 1'b0;
    out1_rdy = 1'b1;
    send_beat("stall.first", 1'b0, 16'h00D0, 1'b0, 1'b0);
    sel     = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 16'h00D1;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d.in_rdy", i), 32'(in_rdy),   32'd0);
      check($sformatf("stall%0d.vld0", i),   32'(out0_vld), 32'd1);
      check($sformatf("stall%0d.dat0", i),   32'(out0_dat), 32'h00D0);
      check($sformatf("stall%0d.cnt0", i),   32'(frm0_cnt), 32'd0);
      tick();
    end
    out0_rdy = 1'b1;
    #1;
    check("release.in_rdy", 32'(in_rdy), 32'd1);
    tick();
    idle_in();
    check("release.vld0",  32'(out0_vld),  32'd1);
    check("release.dat0",  32'(out0_dat),  32'h00D1);
    check("release.last0", 32'(out0_last), 32'd1);
    tick();
    check("release.cnt0", 32'(frm0_cnt), 32'd1);
    check("release.empty", 32'(out0_vld), 32'd0);

    // ---- reset mid-frame with a beat buffered ----
    do_reset();
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;
    send_beat("mid.first", 1'b1, 16'h00E0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.vld0",   32'(out0_vld),  32'd0);
    check("mid.vld1",   32'(out1_vld),  32'd0);
    check("mid.dat1",   32'(out1_dat),  32'd0);
    check("mid.cnt0",   32'(frm0_cnt),  32'd0);
    check("mid.cnt1",   32'(frm1_cnt),  32'd0);
    check("mid.state",  32'(dbg_state), 32'(ST_IDLE));
    check("mid.in_rdy", 32'(in_rdy),    32'd1);
    out0_rdy = 1'b1;
    out1_rdy = 1'b1;
    send_beat("mid.next", 1'b0, 16'h00E1, 1'b1, 1'b0);
    tick();
    check("mid.next_cnt0", 32'(frm0_cnt), 32'd1);
    check("mid.next_cnt1", 32'(frm1_cnt), 32'd0);

    // ---- counter saturation at 3 (CNT_WIDTH=2) ----
    do_reset();
    out0_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_beat($sformatf("sat%0d", i), 1'b0, 16'(16'h0F00 + i), 1'b1, 1'b0);
      check($sformatf("sat%0d.cnt0", i), 32'(frm0_cnt), 32'((i < 3) ? i : 3));
    end
    tick();
    check("sat.cnt0",      32'(frm0_cnt), 32'd3);
    tick();
    check("sat.cnt0_hold", 32'(frm0_cnt), 32'd3);
    check("sat.cnt1",      32'(frm1_cnt), 32'd0);

    // ---- report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Single-input, two-output valid/ready stream demultiplexer: the receive-side counterpart of the 2:1 `mux`, steering each beat of an input stream to output 0 or 1. It sits after the shared symbol/sample path and routes data to one of two downstream consumers, for example a BPSK modulator branch and a loopback/monitor branch. One registered holding stage decouples the outputs. Per-output completed-frame counters are provided for debug.

## Interface
Parameters:
- WIDTH, 16, data width of input and both outputs
- CNT_WIDTH, 16, width of each frame counter

Ports:
- clk_sig  in  1  clock; all logic on the rising edge
- rst_sig  in  1  reset, synchronous, active-high
- sel_sig  in  1  destination select: 0 selects out0, 1 selects out1
- in_vld_sig  in  1  input beat valid
- in_rdy_sig  out  1  input ready
- in_dat_sig  in  WIDTH  input data
- in_last_sig  in  1  last beat of frame
- out0_vld_sig / out1_vld_sig  out  1  output valid, per output
- out0_rdy_sig / out1_rdy_sig  in  1  output ready, per output
- out0_dat_sig / out1_dat_sig  out  WIDTH  output data; both driven from the holding register
- out0_last_sig / out1_last_sig  out  1  output last; both driven from the holding register
- frm0_cnt_sig / frm1_cnt_sig  out  CNT_WIDTH  frames completed on out0 / out1

## Operation
- Push occurs when in_vld_sig & in_rdy_sig. Pop occurs when buf_vld & outN_rdy_sig of the buffered destination.
- Holding register fields: buf_vld, buf_dat, buf_last, buf_dst.
- Push loads dat, last and the effective destination. Pop clears buf_vld unless a push happens in the same cycle.
- in_rdy_sig = ~buf_vld | pop. This is combinational from outN_rdy_sig and the path is intentional.
- outN_vld_sig = buf_vld & (buf_dst == N). The non-selected output never sees valid.
- Frame FSM:
  - IDLE: no frame open. A push takes dest = sel_sig and latches it into lock_dst. If in_last_sig = 0, go to FRAME; otherwise stay in IDLE.
  - FRAME: every push uses lock_dst and ignores sel_sig. A push with in_last_sig = 1 returns the FSM to IDLE.
- frmN_cnt increments by 1 when a beat with buf_last = 1 pops on output N. It saturates at 2^CNT_WIDTH-1 and does not wrap.
- Reset, including mid-frame:
  - buf_vld, buf_dat, buf_last, buf_dst, lock_dst go to 0; state goes to IDLE.
  - Both counters go to 0; all outN_vld/dat/last go to 0.
  - in_rdy_sig is 1 in the first cycle after reset.
  - Any buffered beat is dropped and no counter increments.
- Output stall with a full buffer: in_rdy_sig = 0 and the buffer holds its contents unchanged.

## Timing
- Latency: a beat pushed in cycle t is valid on its output in cycle t+1.
- Throughput: 1 beat/cycle while the destination ready stays high, including simultaneous pop and push.
- Changing sel_sig between frames takes effect on the first beat of the next frame with no bubble. A consecutive frame to the other output can follow in the next cycle.
- Counter update: visible the cycle after the pop of the last beat.
- A single-beat frame (in_last_sig = 1 in IDLE) never enters FRAME.

## Configuration
- DEMUX_FRAME_LOCK_EN defined:
  - The frame FSM above is active.
  - The destination is fixed for a whole frame.
- DEMUX_FRAME_LOCK_EN undefined:
  - No FSM and no lock_dst.
  - The destination is sel_sig sampled at every push.
  - in_last_sig is still carried through to the outputs and still drives the frame counters.

## Structure
- Package stream_demux_pkg holds:
  - state typedef (ST_IDLE, ST_FRAME);
  - destination constants DST_OUT0 = 1'b0 and DST_OUT1 = 1'b1.
- Sub-module stream_reg_slice holds the one-entry valid/ready holding register with a {dst, last, dat} payload. The demux wraps it with the FSM, output valid decode and counters.

## Test plan
- Reset, then push 0x1234 with sel = 1 and last = 1, out1_rdy = 1 -> out1_vld high one cycle later with dat 0x1234. out0_vld stays 0 and frm1_cnt = 1.
- Lock enabled: 4-beat frame 0xA0..0xA3 starting with sel = 0, sel toggled every cycle -> all 4 beats appear on out0 and frm0_cnt = 1.
- Back-to-back frames: frame to out0, then frame to out1, rdy always 1 -> no idle cycle between them and in_rdy constantly 1.
- Hold out0_rdy = 0 for 5 cycles with one beat buffered -> in_rdy = 0 and data stable. On release, the beat pops and the next push is accepted in the same cycle.
- Assert rst_sig mid-frame with a beat buffered -> the next cycle shows vld = 0, counters 0 and state IDLE. The next beat routes per current sel_sig.
- CNT_WIDTH = 2, send 5 single-beat frames to out0 -> frm0_cnt reaches 3 and stays at 3.
